// File: rtl/timer_cmp_core_if.sv
// Slot bus bundle for timer_cmp_core: select, strobes, word address, data and interrupt.
interface timer_cmp_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data, irq
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data, irq
    );
endinterface

// File: rtl/timer_cmp_core.sv
// MMIO timer with prescaler, compare/match flag, free/periodic/one-shot modes,
// overflow flag, level interrupt and a snapshot register for coherent upper-word reads.
module timer_cmp_core #(
    parameter int CNT_W = 48,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    timer_cmp_core_if.slave  bus
);
    localparam int HI_W = CNT_W - 32;

    localparam logic [2:0] A_CNT_LO = 3'd0;
    localparam logic [2:0] A_CNT_HI = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_PSC    = 3'd3;
    localparam logic [2:0] A_CMP_LO = 3'd4;
    localparam logic [2:0] A_CMP_HI = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    localparam logic [1:0] M_PERIODIC = 2'b01;
    localparam logic [1:0] M_ONESHOT  = 2'b10;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [HI_W-1:0]  snap_q, snap_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_W-1:0] psc_reg_q, psc_reg_d;
    logic             go_q, go_d;
    logic [1:0]       mode_q, mode_d;
    logic             irq_en_q, irq_en_d;
    logic             match_ie_q, match_ie_d;
    logic             ovf_ie_q, ovf_ie_d;
    logic             match_flag_q, match_flag_d;
    logic             ovf_flag_q, ovf_flag_d;

    logic       wr, rd;
    logic [2:0] sel;
    logic       tick, match_set, ovf_set, clear;
    logic       unused_bits;

    assign wr  = bus.cs & bus.write;
    assign rd  = bus.cs & bus.read;
    assign sel = bus.addr[2:0];

    // Upper address bits are aliases by design; fold them into a sink.
    assign unused_bits = ^{bus.addr[4:3], bus.wr_data};

    // Next-state logic: prescaler, count update in priority order, then register writes.
    always_comb begin
        count_d      = count_q;
        cmp_d        = cmp_q;
        snap_d       = snap_q;
        psc_cnt_d    = psc_cnt_q;
        psc_reg_d    = psc_reg_q;
        go_d         = go_q;
        mode_d       = mode_q;
        irq_en_d     = irq_en_q;
        match_ie_d   = match_ie_q;
        ovf_ie_d     = ovf_ie_q;
        match_set    = 1'b0;
        ovf_set      = 1'b0;

        clear = wr && (sel == A_CTRL) && bus.wr_data[1];
        tick  = go_q && (psc_cnt_q == psc_reg_q);

        if (go_q) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
        end

        if (tick) begin
            if (count_q == cmp_q) begin
                match_set = 1'b1;
                case (mode_q)
                    M_PERIODIC: count_d = '0;
                    M_ONESHOT:  go_d    = 1'b0;
                    default:    count_d = count_q + 1'b1;
                endcase
            end else if (&count_q) begin
                count_d = '0;
                ovf_set = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        // Clear overrides any tick in the same cycle and suppresses flag updates.
        if (clear) begin
            count_d   = '0;
            psc_cnt_d = '0;
            match_set = 1'b0;
            ovf_set   = 1'b0;
        end

        if (rd && (sel == A_CNT_LO)) begin
            snap_d = count_q[CNT_W-1:32];
        end

        if (wr) begin
            case (sel)
                A_CTRL: begin
                    go_d       = bus.wr_data[0];
                    mode_d     = bus.wr_data[3:2];
                    irq_en_d   = bus.wr_data[4];
                    match_ie_d = bus.wr_data[5];
                    ovf_ie_d   = bus.wr_data[6];
                end
                A_PSC: begin
                    psc_reg_d = bus.wr_data[PSC_W-1:0];
                    psc_cnt_d = '0;
                end
                A_CMP_LO: cmp_d[31:0]       = bus.wr_data;
                A_CMP_HI: cmp_d[CNT_W-1:32] = bus.wr_data[HI_W-1:0];
                default: ;
            endcase
        end

        // Hardware set wins over a same-cycle write-one-to-clear.
        match_flag_d = match_set |
                       (match_flag_q & ~(wr && (sel == A_STATUS) && bus.wr_data[0]));
        ovf_flag_d   = ovf_set |
                       (ovf_flag_q & ~(wr && (sel == A_STATUS) && bus.wr_data[1]));
    end

    // State registers with asynchronous reset; compare resets to all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            cmp_q        <= '1;
            snap_q       <= '0;
            psc_cnt_q    <= '0;
            psc_reg_q    <= '0;
            go_q         <= 1'b0;
            mode_q       <= 2'b00;
            irq_en_q     <= 1'b0;
            match_ie_q   <= 1'b0;
            ovf_ie_q     <= 1'b0;
            match_flag_q <= 1'b0;
            ovf_flag_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            cmp_q        <= cmp_d;
            snap_q       <= snap_d;
            psc_cnt_q    <= psc_cnt_d;
            psc_reg_q    <= psc_reg_d;
            go_q         <= go_d;
            mode_q       <= mode_d;
            irq_en_q     <= irq_en_d;
            match_ie_q   <= match_ie_d;
            ovf_ie_q     <= ovf_ie_d;
            match_flag_q <= match_flag_d;
            ovf_flag_q   <= ovf_flag_d;
        end
    end

    // Read mux, combinational from the address; narrow fields are zero-extended.
    always_comb begin
        logic [31:0] snap_ext, cmp_hi_ext, psc_ext;
        snap_ext   = '0;
        cmp_hi_ext = '0;
        psc_ext    = '0;
        snap_ext[HI_W-1:0]   = snap_q;
        cmp_hi_ext[HI_W-1:0] = cmp_q[CNT_W-1:32];
        psc_ext[PSC_W-1:0]   = psc_reg_q;
        bus.rd_data = '0;
        case (sel)
            A_CNT_LO: bus.rd_data = count_q[31:0];
            A_CNT_HI: bus.rd_data = snap_ext;
            A_CTRL:   bus.rd_data = {25'd0, ovf_ie_q, match_ie_q, irq_en_q, mode_q, 1'b0, go_q};
            A_PSC:    bus.rd_data = psc_ext;
            A_CMP_LO: bus.rd_data = cmp_q[31:0];
            A_CMP_HI: bus.rd_data = cmp_hi_ext;
            A_STATUS: bus.rd_data = {30'd0, ovf_flag_q, match_flag_q};
            default:  bus.rd_data = '0;
        endcase
    end

    // Level interrupt straight from registered state, so reset drops it immediately.
    assign bus.irq = irq_en_q & ((match_flag_q & match_ie_q) | (ovf_flag_q & ovf_ie_q));

endmodule

// File: tb/tb_timer_cmp_core.sv
// Directed bench for timer_cmp_core: inputs change on the falling edge, so each
// bus access spans exactly one rising edge; outputs are sampled before that edge.
module tb_timer_cmp_core;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    timer_cmp_core_if bus ();

    timer_cmp_core #(.CNT_W(48), .PSC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
        bus.addr = a;
        #1 check(tag, bus.rd_data, exp);
        @(negedge clk);
        bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.wr_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        rd_chk(5'd0, 32'h0000_0000, "rst_cnt_lo");
        rd_chk(5'd2, 32'h0000_0000, "rst_ctrl");
        rd_chk(5'd3, 32'h0000_0000, "rst_psc");
        rd_chk(5'd4, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd_chk(5'd5, 32'h0000_FFFF, "rst_cmp_hi");
        rd_chk(5'd6, 32'h0000_0000, "rst_status");

        // T1: free run, prescale 0 then 3
        bus_write(5'd2, 32'h1);
        idle(10);
        rd_chk(5'd0, 32'd10, "t1_lo");
        rd_chk(5'd1, 32'd0,  "t1_hi");
        bus_write(5'd3, 32'd3);
        bus_write(5'd2, 32'h3);
        idle(40);
        rd_chk(5'd0, 32'd10, "t1_psc3_lo");

        // T2: periodic, psc=1, cmp=4, match interrupt
        bus_write(5'd2, 32'h2);
        bus_write(5'd3, 32'd1);
        bus_write(5'd4, 32'd4);
        bus_write(5'd5, 32'd0);
        bus_write(5'd6, 32'h3);
        bus_write(5'd2, 32'h35);
        idle(9);
        rd_chk(5'd0, 32'd4, "t2_cnt_before_match");
        rd_chk(5'd6, 32'h1, "t2_match1");
        check("t2_irq_high", {31'd0, bus.irq}, 32'd1);
        bus_write(5'd6, 32'h1);
        check("t2_irq_low", {31'd0, bus.irq}, 32'd0);
        idle(8);
        rd_chk(5'd6, 32'h1, "t2_match2");
        bus_write(5'd6, 32'h1);
        idle(7);
        bus_write(5'd6, 32'h1);
        rd_chk(5'd6, 32'h1, "t6_set_beats_w1c");
        bus_write(5'd6, 32'h1);
        rd_chk(5'd6, 32'h0, "t2_w1c");
        bus_write(5'd2, 32'h2);

        // T3: one-shot, cmp=7
        bus_write(5'd3, 32'd0);
        bus_write(5'd4, 32'd7);
        bus_write(5'd6, 32'h3);
        bus_write(5'd2, 32'h9);
        idle(10);
        rd_chk(5'd0, 32'd7, "t3_hold");
        rd_chk(5'd2, 32'h8, "t3_go_clr");
        rd_chk(5'd6, 32'h1, "t3_match");
        bus_write(5'd4, 32'd20);
        bus_write(5'd2, 32'h9);
        idle(1);
        rd_chk(5'd0, 32'd8, "t3_resume");
        bus_write(5'd2, 32'h2);

        // T4: overflow from all ones in free mode
        bus_write(5'd4, 32'h100);
        force dut.count_q = 48'hFFFF_FFFF_FFFF;
        @(posedge clk);
        #1 release dut.count_q;
        @(negedge clk);
        rd_chk(5'd0, 32'hFFFF_FFFF, "t4_lo_max");
        rd_chk(5'd1, 32'h0000_FFFF, "t4_hi_max");
        bus_write(5'd6, 32'h3);
        bus_write(5'd2, 32'h1);
        idle(1);
        rd_chk(5'd6, 32'h2, "t4_ovf");
        rd_chk(5'd0, 32'd1, "t4_wrapped");

        // T5: coherent upper-word read through the snapshot
        bus_write(5'd2, 32'h0);
        force dut.count_q = 48'h0001_FFFF_FFFF;
        @(posedge clk);
        #1 release dut.count_q;
        @(negedge clk);
        bus_write(5'd2, 32'h1);
        rd_chk(5'd0, 32'hFFFF_FFFF, "t5_lo");
        idle(2);
        rd_chk(5'd1, 32'h1, "t5_hi_snap");
        rd_chk(5'd0, 32'd3, "t5_lo2");
        rd_chk(5'd1, 32'h2, "t5_hi2");

        // T6: clear+go while running, read/write collision, decode, async reset
        bus_write(5'd2, 32'h3);
        idle(3);
        rd_chk(5'd0, 32'd3, "t6_clear_go");
        bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.addr = 5'd3; bus.wr_data = 32'd5;
        #1 check("t6_rw_old", bus.rd_data, 32'd0);
        @(negedge clk);
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        rd_chk(5'd3,  32'd5,     "t6_rw_new");
        rd_chk(5'h1F, 32'd0,     "t6_reserved");
        rd_chk(5'h0C, 32'h100,   "t6_alias_cmp");
        bus_write(5'd2, 32'h51);
        check("t6_ovf_irq", {31'd0, bus.irq}, 32'd1);
        bus.addr = 5'd0;
        #2 reset = 1'b1;
        #1 check("t6_rst_irq", {31'd0, bus.irq}, 32'd0);
        check("t6_rst_cnt", bus.rd_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk(5'd2, 32'h0,         "t6_rst_ctrl");
        rd_chk(5'd6, 32'h0,         "t6_rst_status");
        rd_chk(5'd4, 32'hFFFF_FFFF, "t6_rst_cmp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
